// File: rtl/uart_rx.sv
// 8N1 UART receiver. It synchronises and majority-votes the serial line, then deframes it.
// Only complete, correctly framed bytes reach rout/rout_en.
module uart_rx #(
    parameter int BAUD_DIV = 234,
    parameter int HALF     = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rout,
    output logic       rout_en,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic          r_sync1;
    logic          r_rx_s;
    logic [2:0]    r_hist;
    logic [1:0]    r_warm;
    logic          r_armed;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;
    logic [7:0]    r_rout;
    logic          r_rout_en;
    logic          r_frame_err;

    logic          w_vote;
    logic          w_armed_next;
    state_t        w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_bitn_next;
    logic [7:0]    w_shift_next;
    logic [7:0]    w_rout_next;
    logic          w_rout_en_next;
    logic          w_frame_err_next;

    assign w_vote = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

    // rx_s shows its reset value for two cycles after reset; r_warm keeps that
    // stale idle level from arming the receiver while the line is really held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_hist  <= 3'b111;
            r_warm  <= 2'b00;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_hist  <= {r_hist[1:0], r_rx_s};
            r_warm  <= {r_warm[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_bitn      <= 3'd0;
            r_shift     <= 8'h00;
            r_rout      <= 8'h00;
            r_rout_en   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_armed     <= w_armed_next;
            r_cnt       <= w_cnt_next;
            r_bitn      <= w_bitn_next;
            r_shift     <= w_shift_next;
            r_rout      <= w_rout_next;
            r_rout_en   <= w_rout_en_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_armed_next     = r_armed;
        w_cnt_next       = r_cnt;
        w_bitn_next      = r_bitn;
        w_shift_next     = r_shift;
        w_rout_next      = r_rout;
        w_rout_en_next   = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next  = '0;
                w_bitn_next = 3'd0;
                if (r_warm[1] && r_rx_s) begin
                    w_armed_next = 1'b1;
                end
                if (r_armed && !r_rx_s) begin
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_next  = '0;
                    w_bitn_next = 3'd0;
                    // A high vote here means the low level did not last: a glitch, not a start bit.
                    w_state_next = w_vote ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_vote, r_shift[7:1]};
                    w_bitn_next  = r_bitn + 3'd1;
                    if (r_bitn == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_bitn_next  = 3'd0;
                    w_state_next = S_IDLE;
                    if (w_vote) begin
                        w_rout_next    = r_shift;
                        w_rout_en_next = 1'b1;
                    end else begin
                        // Disarm so a break never produces a frame.
                        w_frame_err_next = 1'b1;
                        w_armed_next     = 1'b0;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign rout      = r_rout;
    assign rout_en   = r_rout_en;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != S_IDLE);

endmodule
